// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants and types for the RGB to YCbCr block conversion path.
package rgb2ycbcr_pkg;

  localparam int INPUT_WIDTH = 8;
  localparam int PIXEL_COUNT = 64;
  localparam int CORE_COUNT  = 8;
  localparam int PIX_IDX_W   = $clog2(PIXEL_COUNT);

  typedef logic [PIX_IDX_W-1:0] pix_idx_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_START = 2'd1,
    RD_WAIT  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rgb_bank.sv
// One pixel bank: three packed colour vectors written one pixel at a time.
module rgb_bank
  import rgb2ycbcr_pkg::*;
#(
  parameter int WIDTH = INPUT_WIDTH,
  parameter int DEPTH = PIXEL_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         r,
  input  logic [WIDTH-1:0]         g,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH*DEPTH-1:0]   r_all,
  output logic [WIDTH*DEPTH-1:0]   g_all,
  output logic [WIDTH*DEPTH-1:0]   b_all
);

  // Write the incoming pixel into its slot; reset clears the whole bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all <= '0;
      g_all <= '0;
      b_all <= '0;
    end else if (we) begin
      r_all[idx*WIDTH +: WIDTH] <= r;
      g_all[idx*WIDTH +: WIDTH] <= g;
      b_all[idx*WIDTH +: WIDTH] <= b;
    end
  end

endmodule

// File: rtl/rgb_block_buffer.sv
// Ping-pong pixel buffer feeding the block converter.
//
// state    | meaning
// RD_IDLE  | waiting for the read bank to become full
// RD_START | one-cycle conv_start, bus already shows the read bank
// RD_WAIT  | bus held stable until the converter reports done
module rgb_block_buffer #(
  parameter int INPUT_WIDTH = rgb2ycbcr_pkg::INPUT_WIDTH,
  parameter int PIXEL_COUNT = rgb2ycbcr_pkg::PIXEL_COUNT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  input  logic [INPUT_WIDTH-1:0]             pix_r,
  input  logic [INPUT_WIDTH-1:0]             pix_g,
  input  logic [INPUT_WIDTH-1:0]             pix_b,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] g_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] b_all,
  output logic                               conv_start,
  input  logic                               conv_done,
  output logic                               busy,
  output logic [15:0]                        block_cnt
);

  import rgb2ycbcr_pkg::*;

  localparam int IDX_W = $clog2(PIXEL_COUNT);
  localparam int BUS_W = INPUT_WIDTH * PIXEL_COUNT;

  rd_state_t        rd_state;
  logic [1:0]       full;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             fill_done;
  logic             rd_release;
  logic [BUS_W-1:0] bank_r [2];
  logic [BUS_W-1:0] bank_g [2];
  logic [BUS_W-1:0] bank_b [2];

  // Ready depends only on registered state so there is no path from pix_valid.
  assign pix_ready  = rst_n && !full[wr_ptr];
  assign accept     = pix_valid && pix_ready;
  assign fill_done  = accept && (wr_idx == IDX_W'(PIXEL_COUNT - 1));
  assign rd_release = (rd_state == RD_WAIT) && conv_done;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    rgb_bank #(
      .WIDTH (INPUT_WIDTH),
      .DEPTH (PIXEL_COUNT)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && (wr_ptr == 1'(i))),
      .idx   (wr_idx),
      .r     (pix_r),
      .g     (pix_g),
      .b     (pix_b),
      .r_all (bank_r[i]),
      .g_all (bank_g[i]),
      .b_all (bank_b[i])
    );
  end

  // The converter always sees the read bank, including during conv_start.
  assign r_all = rd_ptr ? bank_r[1] : bank_r[0];
  assign g_all = rd_ptr ? bank_g[1] : bank_g[0];
  assign b_all = rd_ptr ? bank_b[1] : bank_b[0];

  // Write index and bank pointer; PIXEL_COUNT is a power of two so wr_idx wraps itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      wr_ptr <= 1'b0;
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
      if (fill_done) wr_ptr <= ~wr_ptr;
    end
  end

  // Full flags; a simultaneous set and clear always land on different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fill_done && (wr_ptr == 1'(i)))        full[i] <= 1'b1;
        else if (rd_release && (rd_ptr == 1'(i)))  full[i] <= 1'b0;
      end
    end
  end

  // Read FSM with registered start pulse, busy flag and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= RD_IDLE;
      rd_ptr     <= 1'b0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      block_cnt  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full[rd_ptr]) begin
            rd_state   <= RD_START;
            conv_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RD_START: begin
          rd_state   <= RD_WAIT;
          conv_start <= 1'b0;
        end
        RD_WAIT: begin
          if (conv_done) begin
            rd_state  <= RD_IDLE;
            busy      <= 1'b0;
            rd_ptr    <= ~rd_ptr;
            block_cnt <= block_cnt + 16'd1;
          end
        end
        default: begin
          rd_state   <= RD_IDLE;
          conv_start <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_block_buffer.sv
// Scoreboard bench for rgb_block_buffer with a simple converter model.
module tb_rgb_block_buffer;

  localparam int W  = 8;
  localparam int N  = 64;
  localparam int BW = W * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [W-1:0]  pix_r = '0;
  logic [W-1:0]  pix_g = '0;
  logic [W-1:0]  pix_b = '0;
  logic [BW-1:0] r_all, g_all, b_all;
  logic          conv_start;
  logic          conv_done;
  logic          busy;
  logic [15:0]   block_cnt;
  logic          model_done = 1'b0;
  logic          manual_done = 1'b0;

  assign conv_done = model_done | manual_done;

  typedef struct {
    logic [BW-1:0] r;
    logic [BW-1:0] g;
    logic [BW-1:0] b;
  } blk_t;

  blk_t exp_q[$];
  blk_t cur;
  blk_t bld;
  int   m_idx = 0;
  int   last_hs = 0;
  int   last_start = 0;
  int   n_starts = 0;
  int   timer = 0;
  int   done_delay = 10;
  int   pix_k = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   at;

  rgb_block_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .r_all      (r_all),
    .g_all      (g_all),
    .b_all      (b_all),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .block_cnt  (block_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and converter model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_idx = 0;
      timer = 0;
      model_done = 1'b0;
      bld = '{default: '0};
    end else begin
      if (timer > 0) begin
        timer--;
        model_done = (timer == 0);
      end else begin
        model_done = 1'b0;
      end
      if (conv_start) begin
        n_starts++;
        last_start = cyc;
        if (exp_q.size() == 0) begin
          check("start_without_block", exp_q.size(), 1);
        end else begin
          cur = exp_q.pop_front();
          check("start_r_all", r_all, cur.r);
          check("start_g_all", g_all, cur.g);
          check("start_b_all", b_all, cur.b);
        end
        timer = done_delay;
      end else if (busy) begin
        check("wait_r_stable", r_all, cur.r);
      end
      if (pix_valid && pix_ready) begin
        bld.r[m_idx*W +: W] = pix_r;
        bld.g[m_idx*W +: W] = pix_g;
        bld.b[m_idx*W +: W] = pix_b;
        m_idx++;
        if (m_idx == N) begin
          exp_q.push_back(bld);
          m_idx = 0;
          last_hs = cyc;
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input int n, input int duty, input int bound);
    int sent = 0;
    int waited = 0;
    while (sent < n) begin
      pix_valid = ($urandom_range(99) < duty);
      pix_r = W'(pix_k);
      pix_g = W'(pix_k + 64);
      pix_b = W'(255 - pix_k);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        sent++;
        pix_k++;
      end
      waited++;
      @(posedge clk); #1;
      if (waited > bound) begin
        check("send_timeout", sent, n);
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input logic [15:0] exp, input int bound, output int when);
    int k = 0;
    when = 0;
    do begin
      @(negedge clk);
      k++;
    end while (block_cnt !== exp && k < bound);
    when = cyc;
    check(tag, block_cnt, exp);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pix_valid = 1'b0;
    manual_done = 1'b0;
    @(negedge clk);
    check("rst_ready", pix_ready, 0);
    check("rst_start", conv_start, 0);
    check("rst_busy", busy, 0);
    check("rst_r_all", r_all, 0);
    check("rst_g_all", g_all, 0);
    check("rst_b_all", b_all, 0);
    check("rst_cnt", block_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", pix_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Single block, timing from last handshake.
    reset_dut();
    done_delay = 10;
    pix_k = 0;
    n_starts = 0;
    send(64, 100, 1000);
    wait_cnt("t1_cnt", 16'd1, 200, at);
    check("t1_starts", n_starts, 1);
    check("t1_start_lat", last_start - last_hs, 2);
    check("t1_cnt_lat", at - last_hs, 13);

    // Two blocks back to back with a slow converter.
    reset_dut();
    done_delay = 200;
    n_starts = 0;
    send(128, 100, 2000);
    @(negedge clk);
    check("t2_ready_low", pix_ready, 0);
    @(posedge clk); #1;
    wait_cnt("t2_cnt1", 16'd1, 400, at);
    check("t2_ready_back", pix_ready, 1);
    wait_cnt("t2_cnt2", 16'd2, 600, at);
    check("t2_starts", n_starts, 2);

    // Random gaps across four blocks.
    reset_dut();
    done_delay = 10;
    n_starts = 0;
    send(256, 50, 5000);
    wait_cnt("t3_cnt", 16'd4, 500, at);
    check("t3_starts", n_starts, 4);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_idx", m_idx, 0);

    // conv_done while idle is ignored.
    manual_done = 1'b1;
    @(posedge clk); #1;
    manual_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_busy", busy, 0);
      check("t4_start", conv_start, 0);
      check("t4_cnt", block_cnt, 4);
    end
    @(posedge clk); #1;

    // Reset mid-block while a conversion is in flight.
    reset_dut();
    done_delay = 200;
    send(64 + 31, 100, 2000);
    @(negedge clk);
    check("t5_busy_before", busy, 1);
    @(posedge clk); #1;
    reset_dut();
    done_delay = 10;
    pix_k = 1000;
    n_starts = 0;
    send(64, 100, 1000);
    wait_cnt("t5_cnt", 16'd1, 200, at);
    check("t5_starts", n_starts, 1);

    // Counter wrap.
    @(negedge clk);
    force dut.block_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.block_cnt;
    @(negedge clk);
    check("t6_forced", block_cnt, 16'hFFFF);
    @(posedge clk); #1;
    send(64, 100, 1000);
    wait_cnt("t6_wrap", 16'd0, 200, at);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
